// File: rtl/trap_entry_ctrl.sv
// trap_entry_ctrl
// Sequences entry into a trap handler. One request is accepted per trap; a synchronous
// exception wins over a pending interrupt. The sequence is: drain the pipeline, write
// xcause/xepc/xtval, then redirect fetch to the trap vector.
//
// Ports
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   priv                     current privilege (00 U, 01 S, 11 M)
//   exc_req/cause/pc/tval    synchronous exception request and its data
//   int_req/cause/pc         interrupt request and its data
//   medeleg, mideleg         exception / interrupt delegation masks
//   tvec                     trap vector selected by the tvec CSR block
//   trap_target_m/_s         privilege the trap is taken to (drives the tvec select)
//   pipe_flush, flush_done   pipeline drain handshake
//   csr_trap_we, trap_*      one-cycle CSR update of xcause/xepc/xtval
//   redirect_valid/_pc       one-cycle fetch redirect
//   busy                     high whenever a trap is in progress
module trap_entry_ctrl #(
    parameter int unsigned VECTORED_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  priv,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause,
    input  logic [63:0] exc_pc,
    input  logic [63:0] exc_tval,
    input  logic        int_req,
    input  logic [4:0]  int_cause,
    input  logic [63:0] int_pc,
    input  logic [63:0] medeleg,
    input  logic [63:0] mideleg,
    input  logic [63:0] tvec,
    output logic        trap_target_m,
    output logic        trap_target_s,
    output logic        pipe_flush,
    input  logic        flush_done,
    output logic        csr_trap_we,
    output logic [63:0] trap_cause,
    output logic [63:0] trap_epc,
    output logic [63:0] trap_tval,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        busy
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFlush    = 2'd1;
    localparam logic [1:0] StWrite    = 2'd2;
    localparam logic [1:0] StRedirect = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_int_q, is_int_d;
    logic        tgt_s_q, tgt_s_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] tval_q, tval_d;
    logic [63:0] rpc_q, rpc_d;

    logic [63:0] vec_base;
    logic        use_vec;
    logic [63:0] target_pc;
    logic        priv_below_m;

    assign priv_below_m = (priv != 2'b11);

    // Mode 1x is reserved and handled as direct; vectoring applies to interrupts only.
    assign vec_base  = {tvec[63:2], 2'b00};
    assign use_vec   = (VECTORED_EN != 0) && is_int_q && (tvec[1:0] == 2'b01);
    assign target_pc = use_vec ? vec_base + {57'b0, cause_q[4:0], 2'b00} : vec_base;

    always_comb begin
        state_d  = state_q;
        is_int_d = is_int_q;
        tgt_s_d  = tgt_s_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        rpc_d    = rpc_q;
        case (state_q)
            StIdle: begin
                if (exc_req) begin
                    state_d  = StFlush;
                    is_int_d = 1'b0;
                    tgt_s_d  = priv_below_m && medeleg[{1'b0, exc_cause}];
                    cause_d  = {59'b0, exc_cause};
                    epc_d    = exc_pc;
                    tval_d   = exc_tval;
                end else if (int_req) begin
                    state_d  = StFlush;
                    is_int_d = 1'b1;
                    tgt_s_d  = priv_below_m && mideleg[{1'b0, int_cause}];
                    cause_d  = {1'b1, 58'b0, int_cause};
                    epc_d    = int_pc;
                    tval_d   = 64'b0;
                end
            end
            StFlush: begin
                if (flush_done) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // tvec is already steered by trap_target_*, so it is valid here.
                rpc_d   = target_pc;
                state_d = StRedirect;
            end
            StRedirect: begin
                state_d = StIdle;
                tgt_s_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            is_int_q <= 1'b0;
            tgt_s_q  <= 1'b0;
            cause_q  <= 64'b0;
            epc_q    <= 64'b0;
            tval_q   <= 64'b0;
            rpc_q    <= 64'b0;
        end else begin
            state_q  <= state_d;
            is_int_q <= is_int_d;
            tgt_s_q  <= tgt_s_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            rpc_q    <= rpc_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign pipe_flush     = (state_q == StFlush);
    assign csr_trap_we    = (state_q == StWrite);
    assign redirect_valid = (state_q == StRedirect);
    assign trap_target_s  = busy && tgt_s_q;
    assign trap_target_m  = busy && !tgt_s_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign trap_tval      = tval_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_entry_ctrl.sv
module tb_trap_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  priv;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [63:0] exc_pc, exc_tval;
    logic        int_req;
    logic [4:0]  int_cause;
    logic [63:0] int_pc;
    logic [63:0] medeleg, mideleg, tvec;
    logic        trap_target_m, trap_target_s, pipe_flush, flush_done, csr_trap_we;
    logic [63:0] trap_cause, trap_epc, trap_tval;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    trap_entry_ctrl #(.VECTORED_EN(1)) dut (
        .clk(clk), .rst(rst), .priv(priv),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_req(int_req), .int_cause(int_cause), .int_pc(int_pc),
        .medeleg(medeleg), .mideleg(mideleg), .tvec(tvec),
        .trap_target_m(trap_target_m), .trap_target_s(trap_target_s),
        .pipe_flush(pipe_flush), .flush_done(flush_done),
        .csr_trap_we(csr_trap_we), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_tval(trap_tval), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a trap in progress and the step it is on
    // (0 draining, 1 writing CSRs, 2 redirecting), plus the data last latched.
    bit          m_active;
    int          m_step;
    bit          m_tgt_s;
    bit          m_is_int;
    logic [63:0] m_cause, m_epc, m_tval, m_rpc;

    int          cnt_pf, cnt_we, cnt_rv, tick_no, rv_at;
    logic [63:0] rv_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_step = 0; m_tgt_s = 0; m_is_int = 0;
        m_cause = '0; m_epc = '0; m_tval = '0; m_rpc = '0;
    endtask

    task automatic model_accept(input bit is_int, input logic [4:0] cause,
                                input logic [63:0] pc, input logic [63:0] tval,
                                input logic [63:0] mask);
        m_active = 1;
        m_step   = 0;
        m_is_int = is_int;
        m_cause  = (is_int ? 64'h8000_0000_0000_0000 : 64'h0) | 64'(cause);
        m_epc    = pc;
        m_tval   = is_int ? 64'h0 : tval;
        m_tgt_s  = (priv != 2'b11) && (((mask >> cause) & 64'h1) == 64'h1);
    endtask

    // Applies the inputs currently driven to the model, as of the next rising edge.
    task automatic model_next();
        logic [63:0] base;
        if (rst) begin
            model_clear();
        end else if (!m_active) begin
            if (exc_req)      model_accept(1'b0, exc_cause, exc_pc, exc_tval, medeleg);
            else if (int_req) model_accept(1'b1, int_cause, int_pc, 64'h0, mideleg);
        end else if (m_step == 0) begin
            if (flush_done) m_step = 1;
        end else if (m_step == 1) begin
            base  = tvec & ~64'h3;
            m_rpc = (m_is_int && tvec[1:0] == 2'b01) ? base + 64'(m_cause[4:0]) * 64'd4 : base;
            m_step = 2;
        end else begin
            m_active = 0;
        end
    endtask

    task automatic check_all();
        chk1("busy", busy, m_active);
        chk1("pipe_flush", pipe_flush, m_active && m_step == 0);
        chk1("csr_trap_we", csr_trap_we, m_active && m_step == 1);
        chk1("redirect_valid", redirect_valid, m_active && m_step == 2);
        chk1("trap_target_m", trap_target_m, m_active && !m_tgt_s);
        chk1("trap_target_s", trap_target_s, m_active && m_tgt_s);
        chk("trap_cause", trap_cause, m_cause);
        chk("trap_epc", trap_epc, m_epc);
        chk("trap_tval", trap_tval, m_tval);
        chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic clear_counts();
        cnt_pf = 0; cnt_we = 0; cnt_rv = 0; tick_no = 0; rv_at = -1; rv_pc = '0;
    endtask

    task automatic tick();
        model_next();
        @(negedge clk);
        check_all();
        tick_no++;
        if (pipe_flush) cnt_pf++;
        if (csr_trap_we) cnt_we++;
        if (redirect_valid) begin
            cnt_rv++;
            rv_at = tick_no;
            rv_pc = redirect_pc;
        end
    endtask

    task automatic quiet_inputs();
        rst = 0; priv = 2'b11; exc_req = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        int_req = 0; int_cause = 0; int_pc = 0; medeleg = 0; mideleg = 0; tvec = 0;
        flush_done = 0;
    endtask

    task automatic reset_now();
        rst = 1;
        model_clear();
        #1;
        check_all();
    endtask

    initial begin
        quiet_inputs();
        model_clear();
        clear_counts();
        reset_now();
        chk1("reset busy", busy, 1'b0);
        chk("reset redirect_pc", redirect_pc, 64'h0);
        tick();
        rst = 0;
        tick();

        // Delegated exception to S, vectored tvec ignored for exceptions, min latency.
        priv = 2'b00; exc_req = 1; exc_cause = 5'd8; medeleg = 64'h100; exc_pc = 64'h1000;
        exc_tval = 64'h55; tvec = 64'h8000_0001; flush_done = 1;
        clear_counts();
        tick();
        exc_req = 0;
        chk1("exc target_s", trap_target_s, 1'b1);
        chk("exc cause", trap_cause, 64'd8);
        chk("exc epc", trap_epc, 64'h1000);
        repeat (4) tick();
        chk("exc latency", 64'(rv_at), 64'd3);
        chk("exc we pulses", 64'(cnt_we), 64'd1);
        chk("exc redirect_pc", rv_pc, 64'h8000_0000);

        // Interrupt in M mode ignores mideleg; vectored target.
        priv = 2'b11; int_req = 1; int_cause = 5'd7; mideleg = 64'h80; int_pc = 64'h4000;
        tvec = 64'h2001;
        clear_counts();
        tick();
        int_req = 0;
        chk1("int target_m", trap_target_m, 1'b1);
        chk("int cause", trap_cause, 64'h8000_0000_0000_0007);
        chk("int tval", trap_tval, 64'h0);
        repeat (4) tick();
        chk("int redirect_pc", rv_pc, 64'h201C);

        // Vectored target wraps modulo 2^64.
        int_req = 1; int_cause = 5'd31; tvec = 64'hFFFF_FFFF_FFFF_FFFD;
        clear_counts();
        tick();
        int_req = 0;
        repeat (4) tick();
        chk("wrap redirect_pc", rv_pc, 64'h78);

        // Simultaneous requests: exception first, held interrupt right after REDIRECT.
        exc_req = 1; exc_cause = 5'd2; int_req = 1; int_cause = 5'd3;
        clear_counts();
        tick();
        exc_req = 0;
        chk("both exc first", trap_cause, 64'd2);
        repeat (3) tick();
        chk1("both idle gap", busy, 1'b0);
        tick();
        chk("both int next", trap_cause, 64'h8000_0000_0000_0003);
        int_req = 0;
        repeat (4) tick();

        // Slow drain: flush_done low for 10 FLUSH cycles.
        exc_req = 1; exc_cause = 5'd4; flush_done = 0;
        clear_counts();
        tick();
        exc_req = 0;
        repeat (10) tick();
        flush_done = 1;
        repeat (4) tick();
        chk("slow pipe_flush cycles", 64'(cnt_pf), 64'd11);
        chk("slow we pulses", 64'(cnt_we), 64'd1);
        chk("slow redirect pulses", 64'(cnt_rv), 64'd1);

        // Reset during FLUSH aborts; held request restarts the sequence.
        exc_req = 1; exc_cause = 5'd5; exc_pc = 64'hABC0; flush_done = 0;
        clear_counts();
        repeat (2) tick();
        reset_now();
        chk1("abort pipe_flush", pipe_flush, 1'b0);
        chk("abort cause", trap_cause, 64'h0);
        tick();
        chk("abort we pulses", 64'(cnt_we), 64'd0);
        chk("abort redirect pulses", 64'(cnt_rv), 64'd0);
        rst = 0; flush_done = 1;
        clear_counts();
        tick();
        exc_req = 0;
        chk("restart epc", trap_epc, 64'hABC0);
        repeat (4) tick();
        chk("restart we pulses", 64'(cnt_we), 64'd1);
        chk("restart redirect pulses", 64'(cnt_rv), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            priv       = 2'($urandom);
            exc_req    = ($urandom_range(0, 99) < 25);
            exc_cause  = 5'($urandom);
            exc_pc     = {$urandom, $urandom};
            exc_tval   = {$urandom, $urandom};
            int_req    = ($urandom_range(0, 99) < 25);
            int_cause  = 5'($urandom);
            int_pc     = {$urandom, $urandom};
            medeleg    = {$urandom, $urandom};
            mideleg    = {$urandom, $urandom};
            tvec       = {$urandom, $urandom};
            flush_done = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 2) begin
                reset_now();
                tick();
                rst = 0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
